// File: rtl/router_pkg.sv
// Shared types and sizing helpers for the router output schedulers.
package router_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    localparam int NUM_PORTS_DEF = 4;
    localparam int MAX_BEATS_DEF = 16;
    localparam int PORT_W        = port_w(NUM_PORTS_DEF);
    localparam int CNT_W         = cnt_w(MAX_BEATS_DEF);

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module router_rr_pick
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int PW = port_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PW-1:0]        ptr_i,
    output logic [NUM_PORTS-1:0] winner_o,
    output logic                 any_o
);

    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the closest request to the pointer wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        winner_o = '0;
        idx      = '0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            idx = PW'((int'(ptr_i) + off) % NUM_PORTS);
            if (req_i[idx]) begin
                winner_o      = '0;
                winner_o[idx] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/router_pkt_scheduler.sv
// Packet-locked round-robin scheduler sharing one registered output link among NUM_PORTS requesters.
module router_pkt_scheduler
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_last,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output logic                            overrun_err
);

    localparam int PW = port_w(NUM_PORTS);
    localparam int CW = cnt_w(MAX_BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    state_t                 state_q;
    logic [PW-1:0]          rr_q, rr_d;
    logic [CW-1:0]          cnt_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic                   busy_q, overrun_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_valid_q, out_last_q;

    logic [NUM_PORTS-1:0]   pick;
    logic                   any_req;
    logic [DATA_WIDTH-1:0]  own_data;
    logic [PW-1:0]          own_idx;
    logic                   xfer, own_last, forced, pkt_end;

    router_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_q),
        .winner_o (pick),
        .any_o    (any_req)
    );

    always_comb begin
        own_data = '0;
        own_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_idx  = PW'(i);
            end
        end
    end

    // grant_q is zero in IDLE, so ready stays low there without extra gating.
    assign req_ready = (state_q == LOCKED && (!out_valid_q || out_ready)) ? grant_q : '0;
    assign xfer      = |(req_valid & req_ready);
    assign own_last  = |(req_last & grant_q);
    assign forced    = !own_last && (cnt_q == LAST_CNT);
    assign pkt_end   = xfer && (own_last || forced);
    assign rr_d      = (own_idx == PW'(NUM_PORTS - 1)) ? '0 : own_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (xfer) begin
                out_data_q  <= own_data;
                out_valid_q <= 1'b1;
                out_last_q  <= own_last || forced;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= pick;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (pkt_end) begin
                            state_q   <= IDLE;
                            grant_q   <= '0;
                            busy_q    <= 1'b0;
                            rr_q      <= rr_d;
                            overrun_q <= forced;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_router_pkt_scheduler.sv
// Randomized bench for router_pkt_scheduler: per-port packet queues, a transaction-level model and directed scenarios.
module tb_router_pkt_scheduler;

    localparam int W = 32;
    localparam int N = 4;
    localparam int MAXB = 16;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   out_data;
    logic           out_valid, out_last;
    logic           out_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           busy, overrun_err;

    router_pkt_scheduler #(.DATA_WIDTH(W), .NUM_PORTS(N), .MAX_BEATS(MAXB)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .grant       (grant),
        .busy        (busy),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus state: pending beats per requester and driver knobs.
    beat_t pq[N][$];
    bit    stall[N];
    bit    popped[N];
    int    vprob = 100;
    bit    rdy_rand = 1'b0;
    bit    rdy_fix = 1'b1;
    bit    mon_en = 1'b0;

    // Reference model: owner (-1 = none), pointer, accepted-beat count, beats expected downstream.
    int    m_owner = -1;
    int    m_ptr = 0;
    int    m_cnt = 0;
    bit    m_ovr = 1'b0;
    beat_t exp_q[$];

    beat_t        out_log[$];
    int           gnt_log[$];
    int           ovr_seen = 0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] prev_pend = '0;
    logic [N*W-1:0] prev_data = '0;
    logic [N-1:0] prev_last = '0;

    // Driver: inputs change 1 time unit after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            bit v;
            if (pq[p].size() == 0 || stall[p]) v = 1'b0;
            else if (req_valid[p] && !popped[p]) v = 1'b1;
            else v = ($urandom_range(99) < vprob);
            popped[p] = 1'b0;
            req_valid[p] = v;
            if (pq[p].size() != 0) begin
                req_data[p*W +: W] = pq[p][0].data;
                req_last[p] = pq[p][0].last;
            end else begin
                req_data[p*W +: W] = '0;
                req_last[p] = 1'b0;
            end
        end
        out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_fix;
    end

    // Monitor and model, evaluated on the falling edge for the upcoming rising edge.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            logic [N-1:0] e_grant, e_ready;
            int g;
            bit found, forced;
            beat_t bt;
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            e_ready = (m_owner >= 0 && (exp_q.size() == 0 || out_ready)) ? e_grant : '0;

            n_vec++; if (grant !== e_grant) begin n_err++; $display("FAIL grant: got %b expected %b at %0t", grant, e_grant, $time); end
            n_vec++; if (busy !== (m_owner >= 0)) begin n_err++; $display("FAIL busy: got %b expected %b at %0t", busy, (m_owner >= 0), $time); end
            n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL req_ready: got %b expected %b at %0t", req_ready, e_ready, $time); end
            n_vec++; if (overrun_err !== m_ovr) begin n_err++; $display("FAIL overrun_err: got %b expected %b at %0t", overrun_err, m_ovr, $time); end
            n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL out_valid: got %b expected %b at %0t", out_valid, (exp_q.size() != 0), $time); end
            if (exp_q.size() != 0) begin
                n_vec++; if (out_data !== exp_q[0].data) begin n_err++; $display("FAIL out_data: got %h expected %h at %0t", out_data, exp_q[0].data, $time); end
                n_vec++; if (out_last !== exp_q[0].last) begin n_err++; $display("FAIL out_last: got %b expected %b at %0t", out_last, exp_q[0].last, $time); end
            end
            for (int p = 0; p < N; p++) begin
                if (prev_pend[p] && req_valid[p]) begin
                    n_vec++;
                    if (req_data[p*W +: W] !== prev_data[p*W +: W] || req_last[p] !== prev_last[p]) begin
                        n_err++; $display("FAIL hold_stable port %0d: got %h/%b expected %h/%b", p, req_data[p*W +: W], req_last[p], prev_data[p*W +: W], prev_last[p]);
                    end
                end
            end

            if (grant != '0 && prev_grant == '0)
                for (int p = 0; p < N; p++) if (grant[p]) gnt_log.push_back(p);
            prev_grant = grant;
            if (overrun_err === 1'b1) ovr_seen++;
            if (out_valid === 1'b1 && out_ready) out_log.push_back(beat_t'{out_data, out_last});

            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            m_ovr = 1'b0;
            if (reset) begin
                m_owner = -1; m_ptr = 0; m_cnt = 0;
                exp_q.delete();
            end else if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        found = 1'b1; m_owner = (m_ptr + k) % N; m_cnt = 0;
                    end
                end
            end else begin
                g = m_owner;
                if (req_valid[g] && e_ready[g] && pq[g].size() != 0) begin
                    bt = pq[g].pop_front();
                    popped[g] = 1'b1;
                    forced = !bt.last && (m_cnt == MAXB - 1);
                    exp_q.push_back(beat_t'{bt.data, bt.last || forced});
                    m_cnt++;
                    if (bt.last || forced) begin
                        m_ptr = (g + 1) % N; m_owner = -1; m_ovr = forced;
                    end
                end
            end
            prev_pend = req_valid & ~e_ready;
            prev_data = req_data;
            prev_last = req_last;
        end
    end

    task automatic push_pkt(input int p, input int len, input logic [W-1:0] base);
        for (int i = 0; i < len; i++) pq[p].push_back(beat_t'{base + W'(i), (i == len - 1)});
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk); #1;
            if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0 &&
                m_owner < 0 && exp_q.size() == 0 && req_valid == '0) ok = 1'b1;
        end
    endtask

    task automatic wait_pq(input int p, input int left, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk); #1;
            if (pq[p].size() <= left) ok = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({out_data, out_valid, out_last, grant, busy, overrun_err, req_ready} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got data=%h v=%b l=%b g=%b busy=%b ovr=%b rdy=%b expected all zero",
                              out_data, out_valid, out_last, grant, busy, overrun_err, req_ready);
        end
        mon_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        out_log.delete(); gnt_log.delete();
        @(posedge clk); #2;
        push_pkt(2, 3, 32'hA);
        drain(50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_drain: got timeout expected completion"); end
        n_vec++; if (gnt_log.size() != 1 || gnt_log[0] != 2) begin n_err++; $display("FAIL single_grant: got %p expected '{2}", gnt_log); end
        n_vec++;
        if (out_log.size() != 3) begin n_err++; $display("FAIL single_count: got %0d expected 3", out_log.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_log[i].data !== W'(32'hA + i) || out_log[i].last !== (i == 2)) begin
                n_err++; $display("FAIL single_beat%0d: got %h/%b expected %h/%b", i, out_log[i].data, out_log[i].last, 32'hA + i, (i == 2));
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        pulse_reset();
        out_log.delete(); gnt_log.delete();
        #1;
        for (int p = 0; p < N; p++) begin
            push_pkt(p, 1, W'(32'h100 + p));
            push_pkt(p, 1, W'(32'h110 + p));
        end
        drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fair_drain: got timeout expected completion"); end
        n_vec++;
        if (gnt_log.size() != 8) begin n_err++; $display("FAIL fair_count: got %0d grants expected 8", gnt_log.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (gnt_log[i] != exp_order[i]) begin n_err++; $display("FAIL fair_order%0d: got %0d expected %0d", i, gnt_log[i], exp_order[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [W-1:0] held;
        out_log.delete(); gnt_log.delete();
        @(posedge clk); #2;
        push_pkt(0, 6, 32'h300);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin @(negedge clk); #1; if (out_log.size() >= 2) ok = 1'b1; end
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_start: got timeout expected two beats out"); end
        rdy_fix = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) held = out_data;
            n_vec++;
            if (out_valid !== 1'b1 || req_ready !== '0 || out_data !== held) begin
                n_err++; $display("FAIL bp_hold%0d: got v=%b rdy=%b data=%h expected v=1 rdy=0000 data=%h", c, out_valid, req_ready, out_data, held);
            end
        end
        rdy_fix = 1'b1;
        drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_drain: got timeout expected completion"); end
        n_vec++;
        if (out_log.size() != 6) begin n_err++; $display("FAIL bp_count: got %0d expected 6", out_log.size()); end
        else for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (out_log[i].data !== W'(32'h300 + i)) begin n_err++; $display("FAIL bp_beat%0d: got %h expected %h", i, out_log[i].data, 32'h300 + i); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int ovr0;
        out_log.delete(); gnt_log.delete();
        ovr0 = ovr_seen;
        @(posedge clk); #2;
        push_pkt(1, 20, 32'h200);
        drain(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ovr_drain: got timeout expected completion"); end
        n_vec++; if (ovr_seen - ovr0 != 1) begin n_err++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_seen - ovr0); end
        n_vec++; if (gnt_log.size() != 2 || gnt_log[0] != 1 || gnt_log[1] != 1) begin n_err++; $display("FAIL ovr_grants: got %p expected '{1,1}", gnt_log); end
        n_vec++;
        if (out_log.size() != 20) begin n_err++; $display("FAIL ovr_count: got %0d expected 20", out_log.size()); end
        else for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (out_log[i].data !== W'(32'h200 + i) || out_log[i].last !== (i == 15 || i == 19)) begin
                n_err++; $display("FAIL ovr_beat%0d: got %h/%b expected %h/%b", i, out_log[i].data, out_log[i].last, 32'h200 + i, (i == 15 || i == 19));
            end
        end
    endtask

    task automatic test_owner_stall();
        bit ok;
        logic [W-1:0] exp_d[5] = '{32'h400, 32'h401, 32'h402, 32'h403, 32'h500};
        out_log.delete(); gnt_log.delete();
        @(posedge clk); #2;
        push_pkt(3, 4, 32'h400);
        push_pkt(0, 1, 32'h500);
        wait_pq(3, 2, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL stall_start: got timeout expected two beats accepted"); end
        stall[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL stall_grant%0d: got %b expected 1000", c, grant); end
        end
        stall[3] = 1'b0;
        drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL stall_drain: got timeout expected completion"); end
        n_vec++; if (gnt_log.size() != 2 || gnt_log[0] != 3 || gnt_log[1] != 0) begin n_err++; $display("FAIL stall_grants: got %p expected '{3,0}", gnt_log); end
        n_vec++;
        if (out_log.size() != 5) begin n_err++; $display("FAIL stall_count: got %0d expected 5", out_log.size()); end
        else for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_log[i].data !== exp_d[i]) begin n_err++; $display("FAIL stall_beat%0d: got %h expected %h", i, out_log[i].data, exp_d[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(posedge clk); #2;
        push_pkt(2, 4, 32'h600);
        wait_pq(2, 2, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_start: got timeout expected beat 2 in flight"); end
        @(posedge clk); #1 reset = 1'b1;
        for (int p = 0; p < N; p++) pq[p].delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_data, out_valid, out_last, grant, busy, overrun_err, req_ready} !== '0) begin
            n_err++; $display("FAIL rmid_outputs: got data=%h v=%b l=%b g=%b busy=%b ovr=%b rdy=%b expected all zero",
                              out_data, out_valid, out_last, grant, busy, overrun_err, req_ready);
        end
        out_log.delete(); gnt_log.delete();
        @(posedge clk); #2;
        push_pkt(0, 1, 32'h700);
        push_pkt(3, 1, 32'h703);
        drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_drain: got timeout expected completion"); end
        n_vec++; if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 3) begin n_err++; $display("FAIL rmid_grants: got %p expected '{0,3}", gnt_log); end
    endtask

    task automatic test_random();
        bit ok;
        int total = 0;
        int exp_ovr = 0;
        int ovr0, len;
        pulse_reset();
        out_log.delete(); gnt_log.delete();
        ovr0 = ovr_seen;
        #1;
        vprob = 60;
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 24);
            push_pkt($urandom_range(N - 1), len, W'($urandom));
            total += len;
            exp_ovr += (len - 1) / MAXB;
        end
        drain(6000, ok);
        rdy_rand = 1'b0;
        vprob = 100;
        n_vec++; if (!ok) begin n_err++; $display("FAIL rand_drain: got timeout expected completion"); end
        n_vec++; if (out_log.size() != total) begin n_err++; $display("FAIL rand_beats: got %0d expected %0d", out_log.size(), total); end
        n_vec++; if (ovr_seen - ovr0 != exp_ovr) begin n_err++; $display("FAIL rand_overruns: got %0d expected %0d", ovr_seen - ovr0, exp_ovr); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_overrun();
        test_owner_stall();
        test_reset_mid();
        test_random();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_scheduler.md
Name: router_pkt_scheduler

Overview:
Packet-granular round-robin scheduler that shares one output link of the 1x4 router between NUM_PORTS input requesters.
- Arbitrates among valid requesters and locks the grant until the winner's last beat.
- Drives a registered output stage with valid/ready backpressure.
- Enforces a maximum packet length and forces release on overrun.

Parameters:
DATA_WIDTH, 32, width of one data beat
NUM_PORTS, 4, number of requesters
MAX_BEATS, 16, maximum beats per packet before forced termination (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_data  input  NUM_PORTS*DATA_WIDTH  per-port beat; port i at [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  input  NUM_PORTS  per-port beat valid
req_last  input  NUM_PORTS  per-port last-beat marker
req_ready  output  NUM_PORTS  per-port accept; at most one bit high
out_data  output  DATA_WIDTH  registered output beat
out_valid  output  1  output beat valid
out_last  output  1  output last-beat marker
out_ready  input  1  downstream accept
grant  output  NUM_PORTS  one-hot current owner, 0 when idle
busy  output  1  high while a packet is locked
overrun_err  output  1  one-cycle pulse on forced termination

Behaviour:
- Reset (clk edge with reset=1): state IDLE, rr pointer 0, beat counter 0. All outputs 0: out_data, out_valid, out_last, grant, busy, overrun_err. req_ready is 0.
- Reset mid-packet discards the packet, including any beat held in the output register.
- Two-state FSM, IDLE and LOCKED.
- IDLE:
  - req_ready = 0.
  - If any req_valid is set, select the first set bit at or after the rr pointer, wrapping modulo NUM_PORTS.
  - Register grant = onehot(winner), busy = 1, go to LOCKED, clear the beat counter.
  - No valid requests: stay in IDLE.
- LOCKED:
  - req_ready[g] = ~out_valid | out_ready; all other ready bits are 0.
  - A beat transfers when req_valid[g] & req_ready[g].
  - On transfer: out_data <= beat, out_valid <= 1, out_last <= req_last[g] | forced, counter += 1.
  - If out_ready is high and there is no transfer, out_valid <= 0.
  - If out_valid = 1 and out_ready = 0, the output register holds its contents.
- Packet end: on a transfer with req_last[g] = 1, go to IDLE, grant <= 0, busy <= 0, rr pointer <= (g+1) mod NUM_PORTS.
- Overrun:
  - Condition: a transfer with req_last[g] = 0 while counter == MAX_BEATS-1.
  - The beat is emitted with out_last = 1 and overrun_err pulses for one cycle.
  - Release follows the packet-end rule.
  - The owner's remaining beats re-arbitrate as a new packet.
- Owner drops req_valid mid-packet: grant is held indefinitely with no idle timeout. Only accepted beats count.
- Latency:
  - req_valid rising in IDLE at edge E0 gives grant after E0.
  - The first beat is accepted at E1, so out_valid is high after E1: 2 cycles minimum.
  - Back-to-back packets have one input-side bubble cycle (the IDLE arbitration cycle).
- Throughput: 1 beat/cycle while the owner is valid and out_ready = 1.
- The rr pointer advances only on packet release, never during IDLE cycles with no grant.
- Counter width is clog2(MAX_BEATS+1). The counter never wraps, because release occurs at MAX_BEATS.
- Requesters hold req_data/req_last stable while req_valid & ~req_ready. The bench asserts this; the DUT does not check it.

Decomposition:
- Shared package router_pkg holds:
  - state enum {IDLE, LOCKED}
  - port-index width localparam clog2(NUM_PORTS)
  - beat-counter width localparam
- Sub-module router_rr_pick: combinational, inputs req vector and pointer, outputs one-hot winner plus any-valid flag. It is reusable by the other router output arbiters.

Test Plan:
- Single requester: port 2 sends 3 beats (A,B,C; last on C) with out_ready=1 -> grant=0100 after E0; out_data A,B,C on consecutive cycles; out_last only with C; busy falls after C.
- Fairness: all 4 ports continuously send 1-beat packets, pointer 0 -> grant order 0,1,2,3,0; each packet followed by one idle arbitration cycle.
- Backpressure: out_ready held 0 for 3 cycles mid-packet -> out_data holds, req_ready[g]=0, no beat lost or duplicated; resumes on release.
- Overrun: MAX_BEATS=16, port 1 sends 20 beats without last -> beat 16 has out_last=1, overrun_err pulses once; port 1 re-arbitrates and beats 17-20 form a new packet.
- Owner stall: port 3 drops valid for 5 cycles mid-packet while port 0 requests -> grant stays 1000, port 0 not served until port 3's last.
- Reset mid-packet: assert reset during beat 2 -> next cycle all outputs 0, state IDLE, pointer 0; a fresh request from port 0 is then granted normally.
